// File: rtl/trg_src_gen.sv
// rtl/trg_src_gen.sv - trigger-source front end: ext sync/filter, cycled trigger, coincidence mask
//
// Purpose: turns raw trigger sources into clock-synchronous, source-masked
// one-shot or level trigger requests for the trigger output controller.
//
// Ports:
//   clk_in           system clock
//   rst_n_in         asynchronous active-low reset
//   ext_trg_in       asynchronous external trigger, active-high
//   coincid_raw_in   coincidence level, synchronous to clk_in
//   trg_src_sel_in   source enables: [0] coincidence, [1] external, [2] cycled
//   trg_enb_in       global enable; 0 suppresses every request output
//   cyc_period_in    cycled period in prescaler ticks; 0 disables the source
//   cnt_clr_in       synchronous clear of both request counters
//   coincid_trg_out  registered, masked coincidence level
//   ext_trg_syn_out  one-clock external trigger request
//   cycled_trg_out   one-clock periodic trigger request
//   ext_trg_cnt_out  accepted external requests (wrapping)
//   cyc_trg_cnt_out  issued cycled requests (wrapping)
module trg_src_gen #(
  parameter int EXT_FILTER_LEN = 4,
  parameter int CYC_UNIT       = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             ext_trg_in,
  input  logic             coincid_raw_in,
  input  logic [2:0]       trg_src_sel_in,
  input  logic             trg_enb_in,
  input  logic [7:0]       cyc_period_in,
  input  logic             cnt_clr_in,
  output logic             coincid_trg_out,
  output logic             ext_trg_syn_out,
  output logic             cycled_trg_out,
  output logic [CNT_W-1:0] ext_trg_cnt_out,
  output logic [CNT_W-1:0] cyc_trg_cnt_out
);

  localparam int            PW       = (CYC_UNIT > 1) ? $clog2(CYC_UNIT) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CYC_UNIT - 1);
  localparam logic [3:0]    FLEN     = 4'(EXT_FILTER_LEN);

  typedef enum logic [1:0] {E_IDLE, E_QUAL, E_HOLD, E_REL} ext_state_t;

  logic          ext_m;
  logic          ext_s;
  ext_state_t    ext_state;
  logic [3:0]    fcnt;
  logic          accept;
  logic [PW-1:0] pre;
  logic [7:0]    per;
  logic          cyc_hold;

  // Coincidence: stays a level, only masked and registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      coincid_trg_out <= 1'b0;
    end else begin
      coincid_trg_out <= coincid_raw_in & trg_src_sel_in[0] & trg_enb_in;
    end
  end

  // Two-flop synchroniser for the asynchronous external trigger.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext_m <= 1'b0;
      ext_s <= 1'b0;
    end else begin
      ext_m <= ext_trg_in;
      ext_s <= ext_m;
    end
  end

  // Deglitch filter: a level must persist FLEN samples to be accepted and
  // FLEN samples to be released, so one long level gives exactly one accept.
  // The filter runs regardless of masking, so a level already held when the
  // source is enabled is never reported.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext_state <= E_IDLE;
      fcnt      <= 4'd0;
      accept    <= 1'b0;
    end else begin
      accept <= 1'b0;
      case (ext_state)
        E_IDLE: begin
          if (ext_s) begin
            if (FLEN == 4'd1) begin
              accept    <= 1'b1;
              ext_state <= E_HOLD;
              fcnt      <= 4'd0;
            end else begin
              ext_state <= E_QUAL;
              fcnt      <= 4'd1;
            end
          end
        end
        E_QUAL: begin
          if (!ext_s) begin
            ext_state <= E_IDLE;
            fcnt      <= 4'd0;
          end else if (fcnt + 4'd1 == FLEN) begin
            accept    <= 1'b1;
            ext_state <= E_HOLD;
            fcnt      <= 4'd0;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        E_HOLD: begin
          if (!ext_s) begin
            if (FLEN == 4'd1) begin
              ext_state <= E_IDLE;
              fcnt      <= 4'd0;
            end else begin
              ext_state <= E_REL;
              fcnt      <= 4'd1;
            end
          end
        end
        E_REL: begin
          if (ext_s) begin
            ext_state <= E_HOLD;
            fcnt      <= 4'd0;
          end else if (fcnt + 4'd1 == FLEN) begin
            ext_state <= E_IDLE;
            fcnt      <= 4'd0;
          end else begin
            fcnt <= fcnt + 4'd1;
          end
        end
        default: begin
          ext_state <= E_IDLE;
          fcnt      <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext_trg_syn_out <= 1'b0;
    end else begin
      ext_trg_syn_out <= accept & trg_src_sel_in[1] & trg_enb_in;
    end
  end

  // Cycled source: prescaler ticks every CYC_UNIT clocks; the period counter
  // fires when it reaches or passes the programmed period, so lowering the
  // period below the running count fires on the next tick.
  assign cyc_hold = ~trg_enb_in | ~trg_src_sel_in[2] | (cyc_period_in == 8'd0);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre            <= '0;
      per            <= 8'd0;
      cycled_trg_out <= 1'b0;
    end else begin
      cycled_trg_out <= 1'b0;
      if (cyc_hold) begin
        pre <= '0;
        per <= 8'd0;
      end else if (pre == PRE_LAST) begin
        pre <= '0;
        if ({1'b0, per} + 9'd1 >= {1'b0, cyc_period_in}) begin
          per            <= 8'd0;
          cycled_trg_out <= 1'b1;
        end else begin
          per <= per + 8'd1;
        end
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

  // Request counters count the issued output pulses; clear wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ext_trg_cnt_out <= '0;
      cyc_trg_cnt_out <= '0;
    end else if (cnt_clr_in) begin
      ext_trg_cnt_out <= '0;
      cyc_trg_cnt_out <= '0;
    end else begin
      if (ext_trg_syn_out) ext_trg_cnt_out <= ext_trg_cnt_out + CNT_W'(1);
      if (cycled_trg_out)  cyc_trg_cnt_out <= cyc_trg_cnt_out + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trg_src_gen.sv
// tb/tb_trg_src_gen.sv - scoreboard bench for trg_src_gen
module tb_trg_src_gen;

  localparam int LEN  = 4;
  localparam int UNIT = 10;
  localparam int CW   = 4;
  localparam int CMSK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ext_trg = 1'b0;
  logic          coincid_raw = 1'b0;
  logic [2:0]    sel = 3'b000;
  logic          enb = 1'b0;
  logic [7:0]    period = 8'd0;
  logic          cnt_clr = 1'b0;
  logic          coincid_out;
  logic          ext_out;
  logic          cycled_out;
  logic [CW-1:0] ext_cnt;
  logic [CW-1:0] cyc_cnt;

  trg_src_gen #(
    .EXT_FILTER_LEN (LEN),
    .CYC_UNIT       (UNIT),
    .CNT_W          (CW)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .ext_trg_in      (ext_trg),
    .coincid_raw_in  (coincid_raw),
    .trg_src_sel_in  (sel),
    .trg_enb_in      (enb),
    .cyc_period_in   (period),
    .cnt_clr_in      (cnt_clr),
    .coincid_trg_out (coincid_out),
    .ext_trg_syn_out (ext_out),
    .cycled_trg_out  (cycled_out),
    .ext_trg_cnt_out (ext_cnt),
    .cyc_trg_cnt_out (cyc_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_ext_q[$];
  int exp_cyc_q[$];
  int exp_ext_cnt = 0;
  int exp_cyc_cnt = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Each observed pulse must match the next expected cycle in its queue.
  always @(negedge clk) begin
    if (ext_out === 1'b1) begin
      if (exp_ext_q.size() > 0) check("ext_time", cyc, exp_ext_q.pop_front());
      else check("ext_extra", 1, 0);
    end
    if (cycled_out === 1'b1) begin
      if (exp_cyc_q.size() > 0) check("cyc_time", cyc, exp_cyc_q.pop_front());
      else check("cyc_extra", 1, 0);
    end
  end

  // Drive point: 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise ext_trg for hi clocks; when fire is set, one pulse is expected
  // 2 sync + LEN filter + 1 output clocks after the rise.
  task automatic ext_burst(input int hi, input bit fire);
    if (fire) begin
      exp_ext_q.push_back(cyc + 2 + LEN + 1);
      exp_ext_cnt++;
    end
    ext_trg = 1'b1;
    tick(hi);
    ext_trg = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_coin"}, coincid_out, 0);
    check({tag, "_ext"}, ext_out, 0);
    check({tag, "_cyc"}, cycled_out, 0);
    check({tag, "_ecnt"}, ext_cnt, 0);
    check({tag, "_ccnt"}, cyc_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // External trigger: long level gives one pulse at +7.
    enb = 1'b1;
    sel = 3'b010;
    ext_burst(20, 1'b1);
    tick(12);
    check("ext_cnt_long", ext_cnt, exp_ext_cnt & CMSK);

    // Glitch shorter than the filter is dropped.
    ext_burst(3, 1'b0);
    tick(12);
    check("ext_cnt_glitch", ext_cnt, exp_ext_cnt & CMSK);

    // Short dropout while held returns to hold: one pulse only.
    ext_burst(4, 1'b1);
    tick(2);
    ext_burst(4, 1'b0);
    tick(12);
    check("ext_cnt_dropout", ext_cnt, exp_ext_cnt & CMSK);

    // Level already held when the source is enabled does not fire.
    sel = 3'b000;
    ext_trg = 1'b1;
    tick(10);
    sel = 3'b010;
    tick(10);
    ext_trg = 1'b0;
    tick(12);
    check("ext_cnt_preheld", ext_cnt, exp_ext_cnt & CMSK);

    // Global disable suppresses a qualified pulse.
    enb = 1'b0;
    ext_burst(6, 1'b0);
    tick(12);
    enb = 1'b1;
    check("ext_cnt_disabled", ext_cnt, exp_ext_cnt & CMSK);

    // Counter wraps modulo 2^CW.
    for (int i = 0; i < 17; i++) begin
      ext_burst(5, 1'b1);
      tick(8);
      check("ext_cnt_wrap", ext_cnt, exp_ext_cnt & CMSK);
    end

    // Clear coinciding with a pulse wins.
    ext_burst(5, 1'b1);
    tick(2);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    exp_ext_cnt = 0;
    check("ext_cnt_clr", ext_cnt, 0);
    tick(10);
    check("ext_cnt_after_clr", ext_cnt, 0);

    // Coincidence: level passed with one clock of delay.
    sel = 3'b001;
    for (int i = 0; i < 7; i++) begin
      check("coin_before_edge", coincid_out, (i >= 1 && i <= 5) ? 1 : 0);
      coincid_raw = (i < 5);
      tick(1);
      check("coin_after_edge", coincid_out, (i < 5) ? 1 : 0);
    end
    enb = 1'b0;
    coincid_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("coin_disabled", coincid_out, 0);
    end
    enb = 1'b1;
    sel = 3'b010;
    tick(1);
    check("coin_masked", coincid_out, 0);
    coincid_raw = 1'b0;
    tick(2);

    // Cycled: period 5 ticks of 10 clocks -> every 50 clocks.
    sel = 3'b100;
    period = 8'd5;
    k = cyc;
    exp_cyc_q.push_back(k + 50);
    exp_cyc_q.push_back(k + 100);
    exp_cyc_q.push_back(k + 150);
    exp_cyc_cnt += 3;
    tick(160);
    period = 8'd0;
    tick(100);
    check("cyc_cnt_stop", cyc_cnt, exp_cyc_cnt & CMSK);
    check("cyc_q_empty", exp_cyc_q.size(), 0);

    // Lowering the period below the running count fires on the next tick.
    period = 8'd5;
    k = cyc;
    tick(35);
    period = 8'd2;
    exp_cyc_q.push_back(k + 40);
    exp_cyc_q.push_back(k + 60);
    exp_cyc_cnt += 2;
    tick(30);
    period = 8'd0;
    tick(20);
    check("cyc_cnt_reduce", cyc_cnt, exp_cyc_cnt & CMSK);

    // Asynchronous reset mid-qualification and mid-prescale.
    sel = 3'b110;
    period = 8'd5;
    ext_trg = 1'b1;
    tick(4);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    exp_ext_cnt = 0;
    exp_cyc_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = cyc;
    exp_ext_q.push_back(k + 2 + LEN + 1);
    exp_cyc_q.push_back(k + 50);
    exp_ext_cnt = 1;
    exp_cyc_cnt = 1;
    tick(15);
    ext_trg = 1'b0;
    tick(45);
    sel = 3'b000;
    period = 8'd0;
    tick(12);
    check("rst_ext_cnt", ext_cnt, exp_ext_cnt & CMSK);
    check("rst_cyc_cnt", cyc_cnt, exp_cyc_cnt & CMSK);

    check("ext_q_left", exp_ext_q.size(), 0);
    check("cyc_q_left", exp_cyc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
